// File: rtl/adau_pkg.sv
// Shared constants and state types for the ADAU acquisition UART link.
package adau_pkg;

    // Bit periods in system clocks, shared with the transmitter side
    localparam int unsigned FAST_clk = 48;
    localparam int unsigned SLOW_clk = 217;

    localparam logic [15:0] SYNC_WORD_DEF    = 16'hFF7F;
    localparam int unsigned CHANNELS_DEF     = 64;
    localparam int unsigned TIMEOUT_BITS_DEF = 32;

    typedef enum logic [1:0] {
        HUNT,
        DATA,
        CHECK
    } deframe_state_e;

    typedef enum logic [2:0] {
        U_IDLE,
        U_START,
        U_DATA,
        U_STOP,
        U_WAIT
    } uart_state_e;

endpackage

// File: rtl/adau_uart_rx.sv
// 8N1 byte receiver: 2-FF synchroniser, mid-bit sampling, stop-bit check.
module adau_uart_rx
    import adau_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = FAST_clk
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       busy_c
);

    localparam int unsigned CNT_W = $clog2(CLK_PER_BIT);
    localparam int unsigned HALF  = CLK_PER_BIT / 2;

    logic        rx_meta_q, rx_sync_q;
    uart_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        byte_valid_q, byte_valid_d;
    logic        frame_err_q, frame_err_d;

    // Line synchroniser, preset to idle-high
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Receiver state and datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= U_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // Start qualification, LSB-first data capture, stop-bit decision
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state_q)
            U_IDLE: begin
                if (!rx_sync_q) begin
                    state_d = U_START;
                    cnt_d   = '0;
                end
            end
            U_START: begin
                if (cnt_q == CNT_W'(HALF - 1)) begin
                    cnt_d = '0;
                    bit_d = '0;
                    state_d = rx_sync_q ? U_IDLE : U_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            U_DATA: begin
                if (cnt_q == CNT_W'(CLK_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = U_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            U_STOP: begin
                if (cnt_q == CNT_W'(CLK_PER_BIT - 1)) begin
                    cnt_d = '0;
                    if (rx_sync_q) begin
                        byte_valid_d = 1'b1;
                        state_d      = U_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = U_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            U_WAIT: begin
                if (rx_sync_q) begin
                    state_d = U_IDLE;
                end
            end
            default: state_d = U_IDLE;
        endcase
    end

    assign byte_data  = shift_q;
    assign byte_valid = byte_valid_q;
    assign frame_err  = frame_err_q;
    assign busy_c     = (state_q != U_IDLE);

endmodule

// File: rtl/adau_frame_rx.sv
// ADAU frame receiver: byte receiver, sync hunt, sample/channel deframing.
// Optional frame buffer enabled by defining ADAU_RX_FRAMEBUF_EN.
module adau_frame_rx
    import adau_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT  = FAST_clk,
    parameter int unsigned CHANNELS     = CHANNELS_DEF,
    parameter logic [15:0] SYNC_WORD    = SYNC_WORD_DEF,
    parameter int unsigned TIMEOUT_BITS = TIMEOUT_BITS_DEF
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        rx,
    output logic [15:0]                 sample,
    output logic                        sample_valid,
    output logic [$clog2(CHANNELS)-1:0] channel,
    output logic                        frame_done,
    output logic                        locked,
    output logic                        sync_err,
    output logic [7:0]                  frame_err_cnt,
    input  logic [$clog2(CHANNELS)-1:0] rd_addr,
    output logic [15:0]                 rd_data
);

    localparam int unsigned CH_W     = $clog2(CHANNELS);
    localparam int unsigned TO_LIMIT = TIMEOUT_BITS * CLK_PER_BIT;
    localparam int unsigned TO_W     = $clog2(TO_LIMIT + 1);

    logic [7:0] byte_data;
    logic       byte_valid, frame_err, rx_busy_c;

    adau_uart_rx #(.CLK_PER_BIT(CLK_PER_BIT)) u_uart (
        .clock      (clock),
        .reset      (reset),
        .rx         (rx),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .frame_err  (frame_err),
        .busy_c     (rx_busy_c)
    );

    deframe_state_e dstate_q, dstate_d;
    logic [CH_W-1:0] chan_q, chan_d, channel_q, channel_d;
    logic        phase_q, phase_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] window_q, window_d, sample_q, sample_d, word_c;
    logic [TO_W-1:0] gap_q, gap_d;
    logic        sample_valid_q, sample_valid_d, frame_done_q, frame_done_d;
    logic        locked_q, locked_d, sync_err_q, sync_err_d;
    logic [7:0]  frame_err_cnt_q, frame_err_cnt_d;

    // Deframer registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dstate_q        <= HUNT;
            chan_q          <= '0;
            phase_q         <= 1'b0;
            hi_q            <= '0;
            window_q        <= '0;
            gap_q           <= '0;
            sample_q        <= '0;
            channel_q       <= '0;
            sample_valid_q  <= 1'b0;
            frame_done_q    <= 1'b0;
            locked_q        <= 1'b0;
            sync_err_q      <= 1'b0;
            frame_err_cnt_q <= '0;
        end else begin
            dstate_q        <= dstate_d;
            chan_q          <= chan_d;
            phase_q         <= phase_d;
            hi_q            <= hi_d;
            window_q        <= window_d;
            gap_q           <= gap_d;
            sample_q        <= sample_d;
            channel_q       <= channel_d;
            sample_valid_q  <= sample_valid_d;
            frame_done_q    <= frame_done_d;
            locked_q        <= locked_d;
            sync_err_q      <= sync_err_d;
            frame_err_cnt_q <= frame_err_cnt_d;
        end
    end

    // Sync hunt, word packing, frame tracking and lock-loss detection
    always_comb begin
        dstate_d        = dstate_q;
        chan_d          = chan_q;
        phase_d         = phase_q;
        hi_d            = hi_q;
        window_d        = window_q;
        gap_d           = gap_q;
        sample_d        = sample_q;
        channel_d       = channel_q;
        sample_valid_d  = 1'b0;
        frame_done_d    = 1'b0;
        locked_d        = locked_q;
        sync_err_d      = 1'b0;
        frame_err_cnt_d = frame_err_cnt_q;
        word_c          = {hi_q, byte_data};

        if (byte_valid) begin
            window_d = {window_q[7:0], byte_data};
        end
        // A bad byte breaks the sliding window so it cannot pair with a later byte
        if (frame_err) begin
            window_d = '0;
            if (frame_err_cnt_q != 8'hFF) begin
                frame_err_cnt_d = frame_err_cnt_q + 8'd1;
            end
        end
        // Idle-line timer only runs while locked and the receiver is quiet
        if (dstate_q == HUNT || byte_valid || rx_busy_c) begin
            gap_d = '0;
        end else if (gap_q != TO_W'(TO_LIMIT)) begin
            gap_d = gap_q + TO_W'(1);
        end

        case (dstate_q)
            HUNT: begin
                if (byte_valid && ({window_q[7:0], byte_data} == SYNC_WORD)) begin
                    dstate_d = DATA;
                    locked_d = 1'b1;
                    chan_d   = '0;
                    phase_d  = 1'b0;
                end
            end
            DATA, CHECK: begin
                if (frame_err || (gap_q == TO_W'(TO_LIMIT))) begin
                    dstate_d = HUNT;
                    locked_d = 1'b0;
                    phase_d  = 1'b0;
                end else if (byte_valid) begin
                    if (!phase_q) begin
                        hi_d    = byte_data;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (dstate_q == DATA) begin
                            sample_d       = word_c;
                            channel_d      = chan_q;
                            sample_valid_d = 1'b1;
                            if (chan_q == CH_W'(CHANNELS - 1)) begin
                                frame_done_d = 1'b1;
                                dstate_d     = CHECK;
                            end else begin
                                chan_d = chan_q + CH_W'(1);
                            end
                        end else if (word_c == SYNC_WORD) begin
                            dstate_d = DATA;
                            chan_d   = '0;
                        end else begin
                            sync_err_d = 1'b1;
                            locked_d   = 1'b0;
                            dstate_d   = HUNT;
                        end
                    end
                end
            end
            default: dstate_d = HUNT;
        endcase
    end

    assign sample        = sample_q;
    assign sample_valid  = sample_valid_q;
    assign channel       = channel_q;
    assign frame_done    = frame_done_q;
    assign locked        = locked_q;
    assign sync_err      = sync_err_q;
    assign frame_err_cnt = frame_err_cnt_q;

`ifdef ADAU_RX_FRAMEBUF_EN
    logic [15:0] mem [CHANNELS];
    logic [15:0] rd_data_q, rd_data_d;

    // Frame buffer write port; contents deliberately survive reset
    always_ff @(posedge clock) begin
        if (sample_valid_q) begin
            mem[channel_q] <= sample_q;
        end
    end

    // Read port lookup
    always_comb begin
        rd_data_d = mem[rd_addr];
    end

    // Registered read data, old value on same-cycle write
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^rd_addr;
    assign rd_data        = '0;
`endif

endmodule

// File: tb/tb_adau_frame_rx.sv
// Directed bench for adau_frame_rx (short bit period, full 64-channel frames).
module tb_adau_frame_rx;

    localparam int CPB   = 4;
    localparam int NCH   = 64;
    localparam int HALF  = CPB / 2;
    // Negedges from the fork point to the sample_valid strobe of a word's low byte
    localparam int LAT_N = HALF + 9 * CPB + 6;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rx    = 1'b1;
    logic [5:0]  rd_addr = '0;
    logic [15:0] sample, rd_data;
    logic        sample_valid, frame_done, locked, sync_err;
    logic [5:0]  channel;
    logic [7:0]  frame_err_cnt;

    always #5 clock = ~clock;

    adau_frame_rx #(
        .CLK_PER_BIT  (CPB),
        .CHANNELS     (NCH),
        .SYNC_WORD    (16'hFF7F),
        .TIMEOUT_BITS (32)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .rx            (rx),
        .sample        (sample),
        .sample_valid  (sample_valid),
        .channel       (channel),
        .frame_done    (frame_done),
        .locked        (locked),
        .sync_err      (sync_err),
        .frame_err_cnt (frame_err_cnt),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data)
    );

    int checks = 0;
    int errors = 0;
    int sv_total = 0, fd_total = 0, se_total = 0, fd_orphan = 0;
    int last_chan = 0, fd_chan = -1;
    logic [15:0] last_sample = '0;

    // Strobe monitor
    always @(negedge clock) begin
        if (sample_valid) begin
            sv_total++;
            last_sample = sample;
            last_chan   = int'(channel);
        end
        if (frame_done) begin
            fd_total++;
            fd_chan = int'(channel);
            if (!sample_valid) fd_orphan++;
        end
        if (sync_err) se_total++;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input int idle_bits);
        @(posedge clock); #1 rx = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge clock);
            #1 rx = b[i];
        end
        repeat (CPB) @(posedge clock);
        #1 rx = stop;
        repeat (CPB) @(posedge clock);
        #1 rx = 1'b1;
        repeat (idle_bits * CPB) @(posedge clock);
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic send_word(input logic [15:0] w, input int exp_chan, input int exp_fd);
        int s0, f0;
        s0 = sv_total;
        f0 = fd_total;
        send_byte(w[15:8], 1'b1, 0);
        send_byte(w[7:0], 1'b1, 0);
        settle(6);
        check("word_sv", sv_total - s0, 1);
        check("word_sample", int'(last_sample), int'(w));
        check("word_chan", last_chan, exp_chan);
        check("word_frame_done", fd_total - f0, exp_fd);
    endtask

    typedef struct {
        logic [7:0]  data;
        int          exp_sv;
        logic [15:0] exp_sample;
        int          exp_chan;
        logic        exp_locked;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int s0, f0, e0, n;
        logic seen;

        // Junk, sync on the FF 7F pair, then the first four words of a frame
        tbl[0]  = '{8'h12, 0, 16'h0000, 0, 1'b0};
        tbl[1]  = '{8'hFF, 0, 16'h0000, 0, 1'b0};
        tbl[2]  = '{8'hFF, 0, 16'h0000, 0, 1'b0};
        tbl[3]  = '{8'h7F, 0, 16'h0000, 0, 1'b1};
        tbl[4]  = '{8'h00, 0, 16'h0000, 0, 1'b1};
        tbl[5]  = '{8'h00, 1, 16'h0000, 0, 1'b1};
        tbl[6]  = '{8'hA5, 0, 16'h0000, 0, 1'b1};
        tbl[7]  = '{8'h5A, 1, 16'hA55A, 1, 1'b1};
        tbl[8]  = '{8'hFF, 0, 16'h0000, 0, 1'b1};
        tbl[9]  = '{8'h7F, 1, 16'hFF7F, 2, 1'b1};
        tbl[10] = '{8'h12, 0, 16'h0000, 0, 1'b1};
        tbl[11] = '{8'h34, 1, 16'h1234, 3, 1'b1};

        // Reset state
        #2 reset = 1'b0;
        repeat (5) @(posedge clock);
        #2;
        check("rst_sample", int'(sample), 0);
        check("rst_valid", int'(sample_valid), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_err_cnt", int'(frame_err_cnt), 0);
        @(posedge clock); #1 reset = 1'b1;
        settle(10);

        // Frame 1: table-driven head, then the remaining words
        for (int i = 0; i < 12; i++) begin
            s0 = sv_total;
            send_byte(tbl[i].data, 1'b1, 0);
            settle(6);
            check("tbl_sv", sv_total - s0, tbl[i].exp_sv);
            if (tbl[i].exp_sv != 0) begin
                check("tbl_sample", int'(last_sample), int'(tbl[i].exp_sample));
                check("tbl_chan", last_chan, tbl[i].exp_chan);
            end
            check("tbl_locked", int'(locked), int'(tbl[i].exp_locked));
        end
        e0 = se_total;
        for (int ch = 4; ch < NCH; ch++) send_word(16'(ch), ch, (ch == NCH - 1) ? 1 : 0);
        check("f1_fd_chan", fd_chan, NCH - 1);
        check("f1_locked", int'(locked), 1);

        // Frame 2 back to back with exact sync
        send_byte(8'hFF, 1'b1, 0);
        send_byte(8'h7F, 1'b1, 0);
        settle(6);
        check("f2_no_sync_err", se_total - e0, 0);
        check("f2_locked", int'(locked), 1);
        for (int ch = 0; ch < NCH; ch++) send_word(16'(ch), ch, (ch == NCH - 1) ? 1 : 0);

        // Wrong word after a full frame
        e0 = se_total;
        send_byte(8'h12, 1'b1, 0);
        send_byte(8'h34, 1'b1, 0);
        settle(6);
        check("sync_err_pulse", se_total - e0, 1);
        check("sync_err_unlock", int'(locked), 0);

        // Relock, then measure word latency on the low byte
        send_byte(8'hFF, 1'b1, 0);
        send_byte(8'h7F, 1'b1, 0);
        settle(6);
        check("relock", int'(locked), 1);
        send_byte(8'h00, 1'b1, 0);
        @(posedge clock); #2;
        s0 = sv_total;
        n = 0;
        seen = 1'b0;
        fork
            send_byte(8'h00, 1'b1, 0);
            begin
                while (n < 100 && !seen) begin
                    @(negedge clock);
                    n++;
                    seen = sample_valid;
                end
            end
        join
        settle(4);
        check("latency", n, LAT_N);
        check("lat_sv", sv_total - s0, 1);
        check("lat_chan", last_chan, 0);

        // Framing error on byte 9 of the frame
        for (int ch = 1; ch < 4; ch++) send_word(16'(ch), ch, 0);
        send_byte(8'h00, 1'b0, 1);
        settle(6);
        check("ferr_cnt", int'(frame_err_cnt), 1);
        check("ferr_unlock", int'(locked), 0);
        s0 = sv_total; f0 = fd_total; e0 = se_total;
        send_byte(8'h04, 1'b1, 0);
        for (int ch = 5; ch < NCH; ch++) begin
            send_byte(8'h00, 1'b1, 0);
            send_byte(8'(ch), 1'b1, 0);
        end
        settle(6);
        check("ferr_no_sv", sv_total - s0, 0);
        check("ferr_no_fd", fd_total - f0, 0);
        check("ferr_no_se", se_total - e0, 0);

        // Inter-byte gap: short idle keeps lock, long idle drops it
        send_byte(8'hFF, 1'b1, 0);
        send_byte(8'h7F, 1'b1, 0);
        settle(6);
        check("to_lock", int'(locked), 1);
        send_word(16'h0042, 0, 0);
        repeat (20 * CPB) @(posedge clock);
        #2;
        check("to_short_idle", int'(locked), 1);
        send_word(16'h0043, 1, 0);
        e0 = se_total;
        repeat (40 * CPB) @(posedge clock);
        settle(2);
        check("to_unlock", int'(locked), 0);
        check("to_no_se", se_total - e0, 0);
        s0 = sv_total;
        send_byte(8'h00, 1'b1, 0);
        send_byte(8'h44, 1'b1, 0);
        settle(6);
        check("to_hunt_no_sv", sv_total - s0, 0);

        // Short low glitch between bytes of a word
        send_byte(8'hFF, 1'b1, 0);
        send_byte(8'h7F, 1'b1, 0);
        settle(6);
        s0 = sv_total;
        send_byte(8'hC3, 1'b1, 0);
        @(posedge clock); #1 rx = 1'b0;
        repeat (CPB / 4) @(posedge clock);
        #1 rx = 1'b1;
        repeat (12) @(posedge clock);
        send_byte(8'h3C, 1'b1, 0);
        settle(6);
        check("glitch_sv", sv_total - s0, 1);
        check("glitch_sample", int'(last_sample), 16'hC33C);
        check("glitch_chan", last_chan, 0);
        check("glitch_err_cnt", int'(frame_err_cnt), 1);

        // Error counter saturation
        repeat (200) send_byte(8'h00, 1'b0, 1);
        settle(6);
        check("err_cnt_201", int'(frame_err_cnt), 201);
        check("err_unlock", int'(locked), 0);
        repeat (100) send_byte(8'h00, 1'b0, 1);
        settle(6);
        check("err_cnt_sat", int'(frame_err_cnt), 255);

        // Reset in the middle of a frame and a byte
        send_byte(8'hFF, 1'b1, 0);
        send_byte(8'h7F, 1'b1, 0);
        send_word(16'h1357, 0, 0);
        @(posedge clock); #1 rx = 1'b0;
        repeat (3 * CPB) @(posedge clock);
        #1 reset = 1'b0;
        #1;
        check("mid_rst_sample", int'(sample), 0);
        check("mid_rst_valid", int'(sample_valid), 0);
        check("mid_rst_channel", int'(channel), 0);
        check("mid_rst_fd", int'(frame_done), 0);
        check("mid_rst_locked", int'(locked), 0);
        check("mid_rst_se", int'(sync_err), 0);
        check("mid_rst_err_cnt", int'(frame_err_cnt), 0);
        check("mid_rst_rd_data", int'(rd_data), 0);
        rx = 1'b1;
        repeat (5) @(posedge clock);
        #1 reset = 1'b1;
        s0 = sv_total; f0 = fd_total; e0 = se_total;
        settle(200);
        check("post_rst_no_sv", sv_total - s0, 0);
        check("post_rst_no_fd", fd_total - f0, 0);
        check("post_rst_no_se", se_total - e0, 0);
        check("post_rst_locked", int'(locked), 0);

        // Final frame, then frame buffer read-back
        send_byte(8'hFF, 1'b1, 0);
        send_byte(8'h7F, 1'b1, 0);
        for (int ch = 0; ch < NCH; ch++) send_word(16'(ch), ch, (ch == NCH - 1) ? 1 : 0);
        check("f3_fd_chan", fd_chan, NCH - 1);
        @(posedge clock); #1 rd_addr = 6'd5;
        @(posedge clock); #2;
`ifdef ADAU_RX_FRAMEBUF_EN
        check("rd_addr5", int'(rd_data), 16'h0005);
`else
        check("rd_addr5", int'(rd_data), 0);
`endif
        @(posedge clock); #1 rd_addr = 6'd63;
        @(posedge clock); #2;
`ifdef ADAU_RX_FRAMEBUF_EN
        check("rd_addr63", int'(rd_data), 16'h003F);
`else
        check("rd_addr63", int'(rd_data), 0);
`endif
        check("fd_without_sv", fd_orphan, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
